// File: rtl/position_encoder.sv
// position_encoder: debounces square pushbuttons into one play request (pos + play_valid/play_ready), pulsing multi_err on multi-button presses
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   buttons[15:0]      : raw asynchronous button levels, bit i = square i
//   play_ready         : consumer accepts the pending play
//   pos[3:0]           : square index, valid while play_valid is high
//   play_valid         : play request, held until accepted
//   multi_err          : one-cycle pulse for a debounced multi-button press
module position_encoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_POS = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] buttons,
  input  logic        play_ready,
  output logic [3:0]  pos,
  output logic        play_valid,
  output logic        multi_err
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] MASK = 16'((17'(1) << NUM_POS) - 17'(1));
  typedef enum logic [1:0] {WAIT_RELEASE, RELEASED, SETTLE, VALID} state_t;
  state_t state_q, state_d;
  logic [15:0] sync_q, btn_s_q, snap_q, snap_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] pos_q, pos_d, idx;
  logic valid_q, valid_d, err_q, err_d, onehot;
  assign onehot = (snap_q != 16'd0) && ((snap_q & (snap_q - 16'd1)) == 16'd0);
  always_comb begin
    idx = 4'd0;
    for (int i = 0; i < 16; i++) if (snap_q[i]) idx = 4'(i);
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    snap_d = snap_q;
    pos_d = pos_q;
    valid_d = valid_q;
    err_d = 1'b0;
    case (state_q)
      WAIT_RELEASE:
        if (btn_s_q != 16'd0) cnt_d = '0;
        else if (cnt_q == LAST) state_d = RELEASED;
        else cnt_d = cnt_q + 1'b1;
      RELEASED:
        if (btn_s_q != 16'd0) begin
          snap_d = btn_s_q;
          cnt_d = '0;
          state_d = SETTLE;
        end
      SETTLE:
        if (btn_s_q == 16'd0) state_d = RELEASED;
        else if (btn_s_q != snap_q) begin
          snap_d = btn_s_q;
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          if (onehot) begin
            pos_d = idx;
            valid_d = 1'b1;
            state_d = VALID;
          end else begin
            err_d = 1'b1;
            cnt_d = '0;
            state_d = WAIT_RELEASE;
          end
        end else cnt_d = cnt_q + 1'b1;
      default:
        if (play_ready) begin
          valid_d = 1'b0;
          cnt_d = '0;
          state_d = WAIT_RELEASE;
        end
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      btn_s_q <= '0;
      state_q <= WAIT_RELEASE;
      cnt_q <= '0;
      snap_q <= '0;
      pos_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      sync_q <= buttons & MASK;
      btn_s_q <= sync_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      snap_q <= snap_d;
      pos_q <= pos_d;
      valid_q <= valid_d;
      err_q <= err_d;
    end
  end
  assign pos = pos_q;
  assign play_valid = valid_q;
  assign multi_err = err_q;
endmodule

// File: doc/position_encoder.md
Name: position_encoder

Overview:
- Converts raw player pushbuttons (one line per board square) into a debounced 4-bit position plus a single "play" request, for the position decoder and board-register logic.
- Each physical press yields exactly one play request.
- Multi-button presses are rejected with an error pulse.
- A held button cannot repeat until all buttons have been released and have settled.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before accepting a press or a release. Minimum legal value is 2. Benches use 4.
- NUM_POS, 9: number of active squares. Button bits at index NUM_POS and above are forced to 0 before any processing. Legal range 1..16.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- buttons  input  16  raw asynchronous pushbutton levels; bit i = square i.
- play_ready  input  1  consumer accepts a play when high while play_valid is high.
- pos  output  4  encoded square index; valid while play_valid is high.
- play_valid  output  1  play request; held until accepted.
- multi_err  output  1  one-cycle pulse when a debounced press has more than one bit set.

Behaviour:
- Synchronizer:
  - Masked buttons pass through 2 flops, giving btn_s. The FSM sees only btn_s.
  - Sync flops reset to 0.
- Counter:
  - cnt, width clog2(DEBOUNCE_CYCLES).
  - Saturation is never reached; the FSM always acts at DEBOUNCE_CYCLES-1.
- States: WAIT_RELEASE, RELEASED, SETTLE, VALID.
- Reset:
  - state=WAIT_RELEASE, cnt=0, snapshot=0, pos=0, play_valid=0, multi_err=0.
  - A button held through reset therefore never produces a play.
- WAIT_RELEASE:
  - If btn_s!=0: cnt=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: go to RELEASED.
  - Else cnt++.
- RELEASED:
  - If btn_s!=0: snapshot=btn_s, cnt=0, go to SETTLE.
- SETTLE:
  - If btn_s==0: go to RELEASED (glitch discarded, no output).
  - Else if btn_s!=snapshot: snapshot=btn_s, cnt=0.
  - Else if cnt==DEBOUNCE_CYCLES-1:
    - If snapshot is one-hot: pos=index of the set bit, play_valid=1, go to VALID.
    - Otherwise: multi_err=1 for one cycle, cnt=0, go to WAIT_RELEASE.
  - Else cnt++.
- VALID:
  - play_valid=1; pos is held constant; buttons are ignored.
  - On a cycle with play_ready=1: play_valid=0 next cycle, cnt=0, go to WAIT_RELEASE.
  - play_ready high on the first cycle play_valid is high counts as acceptance in that cycle.
- Outputs are registered.
  - multi_err is 0 on every cycle except the single pulse cycle.
  - pos keeps its last value after play_valid drops.
- Latency:
  - From RELEASED, when raw buttons go from 0 to a stable one-hot value before rising edge k, play_valid is high after edge k+DEBOUNCE_CYCLES+2.
  - Example: DEBOUNCE_CYCLES=4, change before edge 1 gives play_valid high after edge 7.
- Boundary rules:
  - A bounce that changes the pattern restarts the count.
  - A bounce to all-zero returns to RELEASED and restarts detection on the next non-zero value.
  - Holding a button after acceptance produces no second play until release has been stable for DEBOUNCE_CYCLES.
  - Masked bits never affect state; a press only on a masked bit is equivalent to no press.
  - Synchronous reset in any state, including VALID, drops play_valid the next cycle and enters WAIT_RELEASE.

Test Plan (DEBOUNCE_CYCLES=4, NUM_POS=9):
1. Reset, hold buttons=0 for 6 cycles, then set buttons=16'h0010 with play_ready=1 → play_valid high 1 cycle exactly 7 edges after the change, pos=4. Holding the button 50 more cycles gives no further play.
2. Press buttons=16'h0100 with play_ready=0 for 10 cycles, then play_ready=1 → play_valid high continuously with pos=8. It drops the cycle after play_ready rises. Changing buttons to 16'h0001 while in VALID leaves pos=8.
3. Toggle buttons 0→16'h0002→0→16'h0002 every 2 cycles, then hold → exactly one play with pos=1, issued 7 edges after the final stable change.
4. buttons=16'h0011 held → single multi_err pulse, no play_valid. Release for 6 cycles, then press 16'h0008 → play with pos=3.
5. buttons=16'h0200 (masked, bit 9) held 20 cycles → no play_valid and no multi_err. Adding bit 2 (16'h0204) → play with pos=2.
6. Hold 16'h0040 across a reset pulse and for 20 cycles after → no play. Release for 4+ cycles, press 16'h0040 again → play with pos=6.
